// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request per handshake, performs the access on an
// internal synchronous array after WAIT_STATES cycles and returns a single-cycle response.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [15:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and rsp_valid is a one-cycle strobe with no backpressure.

    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [15:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  access;

    logic                  acc_we;
    logic [15:0]           acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_in_range;
    logic [DEPTH_LOG2-1:0] acc_idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // With zero wait states the access happens on the accept edge, straight from the request inputs.
    assign acc_we       = (state_q == ST_IDLE) ? req_we    : we_q;
    assign acc_addr     = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata    = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_in_range = ((acc_addr >> DEPTH_LOG2) == 16'd0);
    assign acc_idx      = acc_addr[DEPTH_LOG2-1:0];

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (access) begin
            err_d = !acc_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Read data is registered straight out of the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (access) begin
            if (!acc_in_range) begin
                rdata_q <= '1;
            end else if (acc_we) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= mem[acc_idx];
            end
        end
    end

    // Array is not reset, but a write landing on a reset edge is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && access && acc_we && acc_in_range) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances with different wait-state counts, driven
// by directed steps, with responses checked against a queue of expected {err, rdata}.
module tb_data_mem_responder;

    localparam int NI = 4;
    localparam int WS [NI] = '{1, 0, 3, 2};

    logic       clk;
    logic       rst_a       [NI];
    logic       req_valid_a [NI];
    logic       req_ready_a [NI];
    logic       req_we_a    [NI];
    logic [15:0] req_addr_a [NI];
    logic [7:0] req_wdata_a [NI];
    logic       rsp_valid_a [NI];
    logic [7:0] rsp_rdata_a [NI];
    logic       rsp_err_a   [NI];
    logic       busy_a      [NI];

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q [$];
    logic [7:0] model_mem [int];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_responder #(
            .DATA_WIDTH (8),
            .DEPTH_LOG2 (10),
            .WAIT_STATES(WS[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst_a[g]),
            .req_valid(req_valid_a[g]),
            .req_ready(req_ready_a[g]),
            .req_we   (req_we_a[g]),
            .req_addr (req_addr_a[g]),
            .req_wdata(req_wdata_a[g]),
            .rsp_valid(rsp_valid_a[g]),
            .rsp_rdata(rsp_rdata_a[g]),
            .rsp_err  (rsp_err_a[g]),
            .busy     (busy_a[g])
        );
    end

    // Clock and global watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] expect_for(input int i, input logic we, input logic [15:0] addr,
                                              input logic [7:0] wdata);
        int key;
        key = i * 65536 + int'(addr);
        if (addr >= 16'h0400) return {1'b1, 8'hFF};
        if (we) begin
            model_mem[key] = wdata;
            return 9'h000;
        end
        return {1'b0, model_mem[key]};
    endfunction

    task automatic pop_compare(input int i, input string tag);
        logic [8:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_rsp"}, 32'(rsp_valid_a[i]), 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {23'd0, rsp_err_a[i], rsp_rdata_a[i]}, {23'd0, exp});
        end
    endtask

    // Full transaction with latency, busy-length and payload checks; request inputs are
    // scrambled while the responder is busy to prove only accept-time values are used.
    task automatic do_req(input int i, input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                          input string tag);
        int  n;
        int  j;
        int  busy_n;
        bit  seen;
        @(negedge clk);
        n = 0;
        while (req_ready_a[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check({tag, "_ready_timeout"}, 32'(req_ready_a[i]), 32'd1);
        req_valid_a[i] = 1'b1;
        req_we_a[i]    = we;
        req_addr_a[i]  = addr;
        req_wdata_a[i] = wdata;
        exp_q.push_back(expect_for(i, we, addr, wdata));
        @(negedge clk);
        req_valid_a[i] = 1'b0;
        j = 0;
        busy_n = 0;
        seen = 1'b0;
        while (!seen && j < 40) begin
            if (busy_a[i] === 1'b1) busy_n++;
            if (rsp_valid_a[i] === 1'b1) begin
                seen = 1'b1;
                check({tag, "_latency"}, 32'(j), 32'(WS[i]));
                pop_compare(i, {tag, "_rsp"});
            end else begin
                req_we_a[i]    = 1'($urandom_range(0, 1));
                req_addr_a[i]  = 16'($urandom_range(0, 65535));
                req_wdata_a[i] = 8'($urandom_range(0, 255));
                @(negedge clk);
                j++;
            end
        end
        if (!seen) check({tag, "_rsp_timeout"}, 32'(rsp_valid_a[i]), 32'd1);
        @(negedge clk);
        if (busy_a[i] === 1'b1) busy_n++;
        check({tag, "_rsp_one_cycle"}, 32'(rsp_valid_a[i]), 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WS[i] + 1));
    endtask

    initial begin
        int nreq;
        for (int i = 0; i < NI; i++) begin
            rst_a[i]       = 1'b1;
            req_valid_a[i] = 1'b0;
            req_we_a[i]    = 1'b0;
            req_addr_a[i]  = 16'd0;
            req_wdata_a[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) rst_a[i] = 1'b0;
        @(negedge clk);

        // Reset values on every instance
        for (int i = 0; i < NI; i++) begin
            check("reset_outputs",
                  {27'd0, rsp_valid_a[i], busy_a[i], req_ready_a[i], rsp_err_a[i], 1'b0},
                  {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
            check("reset_rdata", 32'(rsp_rdata_a[i]), 32'd0);
        end

        // One wait state: write then read back
        do_req(0, 1'b1, 16'h0010, 8'hA5, "ws1_write");
        do_req(0, 1'b0, 16'h0010, 8'h00, "ws1_read");

        // Zero wait states, req_valid held high across three requests
        @(negedge clk);
        req_valid_a[1] = 1'b1;
        req_we_a[1]    = 1'b1;
        req_addr_a[1]  = 16'h0005;
        req_wdata_a[1] = 8'hC1;
        exp_q.push_back(expect_for(1, 1'b1, 16'h0005, 8'hC1));
        nreq = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("b2b_rsp_valid", 32'(rsp_valid_a[1]), 32'(c % 2 == 0));
            check("b2b_req_ready", 32'(req_ready_a[1]), 32'(c % 2 == 1));
            if (rsp_valid_a[1] === 1'b1) pop_compare(1, "b2b_rsp");
            if (req_ready_a[1] === 1'b0) begin
                if (nreq == 1) begin
                    req_we_a[1]    = 1'b1;
                    req_addr_a[1]  = 16'h0006;
                    req_wdata_a[1] = 8'hC2;
                    exp_q.push_back(expect_for(1, 1'b1, 16'h0006, 8'hC2));
                end else if (nreq == 2) begin
                    req_we_a[1]    = 1'b0;
                    req_addr_a[1]  = 16'h0005;
                    req_wdata_a[1] = 8'h00;
                    exp_q.push_back(expect_for(1, 1'b0, 16'h0005, 8'h00));
                end else begin
                    req_valid_a[1] = 1'b0;
                end
                nreq++;
            end
        end
        do_req(1, 1'b0, 16'h0006, 8'h00, "ws0_read6");

        // Range boundary with three wait states and inputs changing while busy
        do_req(2, 1'b1, 16'h0000, 8'h5A, "rng_seed0");
        do_req(2, 1'b1, 16'h03FF, 8'h3C, "rng_top");
        do_req(2, 1'b1, 16'h0400, 8'h77, "rng_over_write");
        do_req(2, 1'b0, 16'h0000, 8'h00, "rng_read0");
        do_req(2, 1'b0, 16'h03FF, 8'h00, "rng_read_top");
        do_req(2, 1'b0, 16'hFFFF, 8'h00, "rng_over_read");

        // Reset on the access edge of a write with two wait states
        do_req(3, 1'b1, 16'h0020, 8'h99, "rst_seed");
        @(negedge clk);
        req_valid_a[3] = 1'b1;
        req_we_a[3]    = 1'b1;
        req_addr_a[3]  = 16'h0020;
        req_wdata_a[3] = 8'h11;
        @(negedge clk);
        req_valid_a[3] = 1'b0;
        @(negedge clk);
        check("rst_pre_busy", 32'(busy_a[3]), 32'd1);
        rst_a[3] = 1'b1;
        @(negedge clk);
        rst_a[3] = 1'b0;
        check("rst_no_rsp", 32'(rsp_valid_a[3]), 32'd0);
        check("rst_ready", 32'(req_ready_a[3]), 32'd1);
        check("rst_busy", 32'(busy_a[3]), 32'd0);
        check("rst_rdata", {23'd0, rsp_err_a[3], rsp_rdata_a[3]}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_after_rst", {29'd0, rsp_valid_a[3], busy_a[3], req_ready_a[3]}, 32'd1);
        end
        do_req(3, 1'b0, 16'h0020, 8'h00, "rst_read_back");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the processor's data-memory port. It accepts one request per handshake: the 16-bit address from the address-selection stage, plus a write enable and write data. It performs the access on an internal synchronous array after a configurable number of wait states and returns a single-cycle response. It is the target end of the address path that selects between PC-relative, SP, R0 and forwarded operand addresses.

## Interface

Parameters:

- DATA_WIDTH, 8, data word width
- DEPTH_LOG2, 10, implemented words = 2^DEPTH_LOG2; must be ≤ 16
- WAIT_STATES, 1, cycles between accept and access; legal range 0..7

Ports:

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = write, 0 = read; sampled on accept
- req_addr  in  16  byte address from the address selector; sampled on accept
- req_wdata  in  DATA_WIDTH  write data; sampled on accept
- rsp_valid  out  1  response strobe, exactly one cycle per accepted request
- rsp_rdata  out  DATA_WIDTH  read data; qualified by rsp_valid
- rsp_err  out  1  address out of range; qualified by rsp_valid
- busy  out  1  high in WAIT or RESP

## Operation

- FSM states: IDLE, WAIT, RESP. Wait-state counter is 3 bits.
- IDLE:
  - req_ready = 1.
  - Accept occurs when req_valid & req_ready.
  - On accept, latch req_we, req_addr and req_wdata.
  - WAIT_STATES = 0: perform the access on the same edge, then go to RESP.
  - WAIT_STATES > 0: load cnt = WAIT_STATES−1, then go to WAIT.
- WAIT:
  - If cnt == 0: perform the access, then go to RESP.
  - Otherwise: decrement cnt.
  - req_valid is ignored.
- RESP:
  - rsp_valid = 1 for this one cycle only.
  - Next state is IDLE unconditionally; there is no response backpressure.
- Access rules, all using latched values:
  - In range means addr[15:DEPTH_LOG2] == 0.
  - In-range write: mem[addr[DEPTH_LOG2−1:0]] ← wdata. rsp_rdata = 0 and rsp_err = 0.
  - In-range read: rsp_rdata ← mem[addr], registered. rsp_err = 0.
  - Out-of-range access: no array access, and writes are discarded. rsp_rdata = all-ones (8'hFF for default width). rsp_err = 1.
- Read-after-write: a read accepted after a write's response returns the newly written value. No bypass is needed because requests are serialized.
- rsp_rdata and rsp_err hold their last values outside RESP. Consumers must qualify them with rsp_valid.

## Timing

- Reset values:
  - State: IDLE.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, busy = 0, cnt = 0.
  - req_ready = 1 from the first cycle after reset.
  - Array contents are not reset.
- Accept on edge k. Access occurs on edge k+WAIT_STATES.
- rsp_valid is high in the cycle after edge k+WAIT_STATES and is sampled by the consumer at edge k+WAIT_STATES+1.
- The earliest next accept is edge k+WAIT_STATES+2. Throughput is one request per WAIT_STATES+2 cycles.
- req_ready and busy decode combinationally from state. They are exact complements.
- rst asserted in WAIT or RESP:
  - Next state is IDLE and the outstanding response is dropped.
  - A write whose access edge coincides with the rst edge is not performed. Reset wins.
- rst has priority over accept. A req_valid present on a reset edge is not accepted.
- An out-of-range address wraps to nothing: 16'h0400 with DEPTH_LOG2=10 is an error and never aliases to 16'h0000.

## Test plan

- Write then read, WAIT_STATES=1:
  - Write 8'hA5 to 16'h0010, accepted at edge 0 → rsp_valid sampled at edge 2, rsp_err=0.
  - Read 16'h0010, accepted at edge 3 → rsp_rdata=8'hA5 at edge 5.
- WAIT_STATES=0, back-to-back req_valid held high:
  - Requests are accepted at edges 0, 2, 4.
  - Each rsp_valid is exactly one cycle, following its accept by one cycle.
  - req_ready=0 on alternate cycles.
- Range boundary, DEPTH_LOG2=10:
  - Write 8'h3C to 16'h03FF → rsp_err=0.
  - Write 8'h77 to 16'h0400 → rsp_err=1, rsp_rdata=8'hFF.
  - Read 16'h0000 → original contents, unchanged by the discarded write.
  - Read 16'h03FF → 8'h3C.
- Request changes while busy, WAIT_STATES=3:
  - Change req_addr and req_wdata during WAIT → response reflects only the values latched at accept.
  - busy=1 for exactly 4 cycles per request.
- Reset mid-operation, WAIT_STATES=2:
  - Write 8'h11 to 16'h0020 after it previously held 8'h99.
  - Assert rst on the access edge → no rsp_valid; state is IDLE with req_ready=1 the next cycle.
  - A subsequent read of 16'h0020 returns 8'h99.
- Post-reset idle: hold req_valid=0 for 10 cycles after rst → rsp_valid=0, busy=0, req_ready=1 throughout.
